// File: rtl/calc_pkg.sv
// calc_pkg: key codes, ALU/entry enums, operand commands and the WIDTH/DIGITS fit check
package calc_pkg;
  localparam logic [4:0] KEY_ADD  = 5'b10000;
  localparam logic [4:0] KEY_SUB  = 5'b10001;
  localparam logic [4:0] KEY_MUL  = 5'b10010;
  localparam logic [4:0] KEY_DIV  = 5'b10011;
  localparam logic [4:0] KEY_EQ   = 5'b10100;
  localparam logic [4:0] KEY_AC   = 5'b10101;
  localparam logic [4:0] KEY_NEG  = 5'b10110;
  localparam logic [4:0] KEY_BKSP = 5'b01111;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV} alu_op_t;

  typedef enum logic [2:0] {ST_A, ST_OP, ST_B, ST_ISSUE, ST_WAIT, ST_RES, ST_ERR} entry_state_t;

  typedef enum logic [2:0] {
    CMD_NONE, CMD_CLEAR, CMD_LOAD_DIGIT, CMD_APPEND, CMD_NEG, CMD_LOAD_VALUE, CMD_BKSP
  } entry_cmd_t;

  // True when the largest DIGITS-digit magnitude is representable as a positive WIDTH-bit value.
  function automatic bit digits_fit(input int width, input int digits);
    longint p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return (p - 1) <= ((longint'(1) <<< (width - 1)) - 1);
  endfunction

  localparam bit DEFAULT_CFG_OK = digits_fit(16, 4);
endpackage

// File: rtl/calc_input_fsm_operand_entry.sv
// operand_entry: one sign/magnitude/digit-count operand with decimal editing commands
module operand_entry
  import calc_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  entry_cmd_t       cmd,
  input  logic [3:0]       digit,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value
);
  localparam int CW = $clog2(DIGITS + 1);
  logic             sign;
  logic [WIDTH-1:0] mag;
  logic [CW-1:0]    count;
  logic             append_ok;
  // Digits beyond DIGITS are dropped and leading zeros never count as digits.
  assign append_ok = (count < CW'(DIGITS)) && !(mag == '0 && digit == 4'd0);
  assign value = sign ? -mag : mag;
  // Apply one editing command per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign  <= 1'b0;
      mag   <= '0;
      count <= '0;
    end else begin
      case (cmd)
        CMD_CLEAR: begin
          sign  <= 1'b0;
          mag   <= '0;
          count <= '0;
        end
        CMD_LOAD_DIGIT: begin
          sign  <= 1'b0;
          mag   <= WIDTH'(digit);
          count <= CW'(digit != 4'd0);
        end
        CMD_APPEND: if (append_ok) begin
          mag   <= mag * WIDTH'(10) + WIDTH'(digit);
          count <= count + 1'b1;
        end
        CMD_NEG: sign <= !sign;
        CMD_LOAD_VALUE: begin
          sign  <= load_value[WIDTH-1];
          mag   <= load_value[WIDTH-1] ? -load_value : load_value;
          count <= CW'(DIGITS);
        end
        CMD_BKSP: begin
          mag   <= mag / WIDTH'(10);
          count <= (count == '0) ? '0 : count - 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/calc_input_fsm.sv
// calc_input_fsm: calculator key-entry FSM feeding the ALU; CALC_INPUT_BACKSPACE_EN enables key 15 as backspace
module calc_input_fsm
  import calc_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       i_key,
  input  logic             i_key_valid,
  output logic             o_key_ready,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [1:0]       o_alu_op,
  output logic             o_alu_valid,
  input  logic             i_alu_ready,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_error,
  input  logic             i_alu_result_valid,
  output logic [WIDTH-1:0] o_display,
  output logic             o_display_error
);
  entry_state_t     state, state_n;
  alu_op_t          op_reg, op_n, chain_op, chain_op_n, key_op;
  logic             chain, chain_n;
  entry_cmd_t       a_cmd, b_cmd;
  logic [WIDTH-1:0] a_val, b_val;
  logic             fire, is_digit, is_op, is_eq, is_ac, is_neg, is_bksp;
  assign fire     = i_key_valid && o_key_ready;
  assign is_digit = fire && !i_key[4] && (i_key[3:0] <= 4'd9);
  assign is_op    = fire && (i_key[4:2] == 3'b100);
  assign is_eq    = fire && (i_key == KEY_EQ);
  assign is_ac    = fire && (i_key == KEY_AC);
  assign is_neg   = fire && (i_key == KEY_NEG);
  assign key_op   = alu_op_t'(i_key[1:0]);
`ifdef CALC_INPUT_BACKSPACE_EN
  assign is_bksp  = fire && (i_key == KEY_BKSP);
`else
  assign is_bksp  = 1'b0;
`endif
  assign o_key_ready     = (state != ST_ISSUE) && (state != ST_WAIT);
  assign o_alu_valid     = (state == ST_ISSUE);
  assign o_alu_a         = a_val;
  assign o_alu_b         = b_val;
  assign o_alu_op        = op_reg;
  assign o_display_error = (state == ST_ERR);
  assign o_display       = (state == ST_ERR) ? '0 :
                           (state == ST_B || state == ST_ISSUE || state == ST_WAIT) ? b_val : a_val;
  operand_entry #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_a (
    .clk(clk), .rst(rst), .cmd(a_cmd), .digit(i_key[3:0]), .load_value(i_alu_result), .value(a_val)
  );
  operand_entry #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_b (
    .clk(clk), .rst(rst), .cmd(b_cmd), .digit(i_key[3:0]), .load_value(i_alu_result), .value(b_val)
  );
  // State, pending operator and chained operator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_A;
      op_reg   <= ALU_ADD;
      chain    <= 1'b0;
      chain_op <= ALU_ADD;
    end else begin
      state    <= state_n;
      op_reg   <= op_n;
      chain    <= chain_n;
      chain_op <= chain_op_n;
    end
  end
  // Next state and operand commands; B is cleared on every entry to OP so OP keys simply edit it.
  always_comb begin
    state_n    = state;
    op_n       = op_reg;
    chain_n    = chain;
    chain_op_n = chain_op;
    a_cmd      = CMD_NONE;
    b_cmd      = CMD_NONE;
    if (is_ac) begin
      state_n = ST_A;
      op_n    = ALU_ADD;
      chain_n = 1'b0;
      a_cmd   = CMD_CLEAR;
      b_cmd   = CMD_CLEAR;
    end else begin
      case (state)
        ST_A: begin
          a_cmd = is_digit ? CMD_APPEND : is_neg ? CMD_NEG : is_bksp ? CMD_BKSP : CMD_NONE;
          if (is_op) begin
            op_n    = key_op;
            state_n = ST_OP;
            b_cmd   = CMD_CLEAR;
          end
        end
        ST_OP: begin
          b_cmd   = is_digit ? CMD_APPEND : is_neg ? CMD_NEG : CMD_NONE;
          state_n = (is_digit || is_neg) ? ST_B : ST_OP;
          op_n    = is_op ? key_op : op_reg;
        end
        ST_B: begin
          b_cmd = is_digit ? CMD_APPEND : is_neg ? CMD_NEG : is_bksp ? CMD_BKSP : CMD_NONE;
          if (is_eq || is_op) begin
            chain_n    = is_op;
            chain_op_n = key_op;
            state_n    = ST_ISSUE;
          end
        end
        ST_ISSUE: state_n = i_alu_ready ? ST_WAIT : ST_ISSUE;
        ST_WAIT: if (i_alu_result_valid) begin
          if (i_alu_error) state_n = ST_ERR;
          else begin
            a_cmd   = CMD_LOAD_VALUE;
            b_cmd   = chain ? CMD_CLEAR : CMD_NONE;
            op_n    = chain ? chain_op : op_reg;
            state_n = chain ? ST_OP : ST_RES;
          end
        end
        ST_RES: begin
          a_cmd = is_digit ? CMD_LOAD_DIGIT : is_neg ? CMD_NEG : CMD_NONE;
          if (is_digit) state_n = ST_A;
          if (is_op) begin
            op_n    = key_op;
            state_n = ST_OP;
            b_cmd   = CMD_CLEAR;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_calc_input_fsm.sv
// tb_calc_input_fsm: directed self-checking bench for calc_input_fsm
module tb_calc_input_fsm;
  import calc_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  i_key = '0;
  logic        i_key_valid = 1'b0;
  logic        i_alu_ready = 1'b0;
  logic [15:0] i_alu_result = '0;
  logic        i_alu_error = 1'b0;
  logic        i_alu_result_valid = 1'b0;
  logic        o_key_ready, o_alu_valid, o_display_error;
  logic [15:0] o_alu_a, o_alu_b, o_display;
  logic [1:0]  o_alu_op;
  logic [15:0] cap_a, cap_b;
  logic [1:0]  cap_op;
  logic        got;
  int          checks = 0;
  int          errors = 0;

  calc_input_fsm #(.WIDTH(16), .DIGITS(4)) dut (
    .clk(clk), .rst(rst), .i_key(i_key), .i_key_valid(i_key_valid), .o_key_ready(o_key_ready),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op), .o_alu_valid(o_alu_valid),
    .i_alu_ready(i_alu_ready), .i_alu_result(i_alu_result), .i_alu_error(i_alu_error),
    .i_alu_result_valid(i_alu_result_valid), .o_display(o_display), .o_display_error(o_display_error)
  );

  always #5 clk = ~clk;

  task automatic press(input logic [4:0] k);
    i_key = k;
    i_key_valid = 1'b1;
    @(posedge clk);
    #1;
    i_key_valid = 1'b0;
  endtask

  task automatic accept_request();
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (o_alu_valid) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL alu_request_timeout valid=%b required 1", o_alu_valid);
    end
    cap_a = o_alu_a;
    cap_b = o_alu_b;
    cap_op = o_alu_op;
    i_alu_ready = 1'b1;
    @(posedge clk);
    #1;
    i_alu_ready = 1'b0;
  endtask

  task automatic give_result(input logic [15:0] r, input logic e);
    i_alu_result = r;
    i_alu_error = e;
    i_alu_result_valid = 1'b1;
    @(posedge clk);
    #1;
    i_alu_result_valid = 1'b0;
    i_alu_error = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (o_key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got=%b exp=1", o_key_ready); end
    checks++; if (o_alu_valid !== 1'b0) begin errors++; $display("FAIL reset_alu_valid got=%b exp=0", o_alu_valid); end
    checks++; if (o_alu_a !== 16'd0 || o_alu_b !== 16'd0 || o_alu_op !== 2'd0) begin errors++; $display("FAIL reset_alu_bus got=%h/%h/%0d exp=0/0/0", o_alu_a, o_alu_b, o_alu_op); end
    checks++; if (o_display !== 16'd0 || o_display_error !== 1'b0) begin errors++; $display("FAIL reset_display got=%h err=%b exp=0 err=0", o_display, o_display_error); end
    checks++; if (dut.state !== ST_A) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, ST_A); end
  endtask

  task automatic test_basic();
    press(5'd1); press(5'd2);
    checks++; if (o_display !== 16'd12) begin errors++; $display("FAIL basic_entry_a got=%0d exp=12", o_display); end
    press(KEY_ADD); press(5'd3); press(5'd4);
    checks++; if (o_display !== 16'd34) begin errors++; $display("FAIL basic_entry_b got=%0d exp=34", o_display); end
    press(KEY_EQ);
    checks++; if (o_alu_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_next_cycle got=%b exp=1", o_alu_valid); end
    accept_request();
    checks++; if (cap_a !== 16'd12 || cap_b !== 16'd34 || cap_op !== 2'd0) begin errors++; $display("FAIL basic_request got=%0d/%0d/%0d exp=12/34/0", cap_a, cap_b, cap_op); end
    give_result(16'd46, 1'b0);
    checks++; if (o_display !== 16'd46) begin errors++; $display("FAIL basic_result got=%0d exp=46", o_display); end
    checks++; if (dut.state !== ST_RES) begin errors++; $display("FAIL basic_state got=%0d exp=%0d", dut.state, ST_RES); end
  endtask

  task automatic test_digit_limit();
    press(KEY_AC);
    for (int i = 0; i < 5; i++) press(5'd9);
    checks++; if (o_display !== 16'd9999) begin errors++; $display("FAIL limit_display got=%0d exp=9999", o_display); end
    press(KEY_NEG);
    checks++; if (o_display !== 16'hD8F1) begin errors++; $display("FAIL limit_neg got=%h exp=d8f1", o_display); end
  endtask

  task automatic test_chain();
    press(KEY_AC); press(5'd8); press(KEY_MUL); press(5'd2); press(KEY_ADD);
    accept_request();
    checks++; if (cap_a !== 16'd8 || cap_b !== 16'd2 || cap_op !== 2'd2) begin errors++; $display("FAIL chain_first got=%0d/%0d/%0d exp=8/2/2", cap_a, cap_b, cap_op); end
    give_result(16'd16, 1'b0);
    checks++; if (dut.state !== ST_OP || dut.op_reg !== ALU_ADD) begin errors++; $display("FAIL chain_state got=%0d op=%0d exp=%0d op=0", dut.state, dut.op_reg, ST_OP); end
    checks++; if (o_display !== 16'd16) begin errors++; $display("FAIL chain_display got=%0d exp=16", o_display); end
    press(5'd4);
    checks++; if (o_display !== 16'd4) begin errors++; $display("FAIL chain_b got=%0d exp=4", o_display); end
    press(KEY_EQ);
    accept_request();
    checks++; if (cap_a !== 16'd16 || cap_b !== 16'd4 || cap_op !== 2'd0) begin errors++; $display("FAIL chain_second got=%0d/%0d/%0d exp=16/4/0", cap_a, cap_b, cap_op); end
    give_result(16'd20, 1'b0);
    checks++; if (o_display !== 16'd20) begin errors++; $display("FAIL chain_result got=%0d exp=20", o_display); end
  endtask

  task automatic test_error();
    press(KEY_AC); press(5'd5); press(KEY_DIV); press(5'd0); press(KEY_EQ);
    accept_request();
    checks++; if (cap_b !== 16'd0 || cap_op !== 2'd3) begin errors++; $display("FAIL err_request got=%0d/%0d exp=0/3", cap_b, cap_op); end
    give_result(16'd0, 1'b1);
    checks++; if (o_display_error !== 1'b1 || o_display !== 16'd0) begin errors++; $display("FAIL err_display got=%h err=%b exp=0 err=1", o_display, o_display_error); end
    press(5'd7);
    checks++; if (o_display_error !== 1'b1 || o_display !== 16'd0) begin errors++; $display("FAIL err_digit_ignored got=%h err=%b exp=0 err=1", o_display, o_display_error); end
    press(KEY_AC);
    checks++; if (o_display_error !== 1'b0 || o_display !== 16'd0 || dut.state !== ST_A) begin errors++; $display("FAIL err_clear got=%h err=%b st=%0d exp=0 err=0 st=0", o_display, o_display_error, dut.state); end
  endtask

  task automatic test_stray_result();
    press(5'd3);
    give_result(16'd99, 1'b0);
    checks++; if (o_display !== 16'd3 || dut.state !== ST_A) begin errors++; $display("FAIL stray_result got=%0d st=%0d exp=3 st=0", o_display, dut.state); end
  endtask

  task automatic test_stall_reset();
    press(KEY_AC); press(5'd1); press(KEY_SUB); press(5'd2); press(KEY_EQ);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_alu_valid !== 1'b1 || o_alu_a !== 16'd1 || o_alu_b !== 16'd2 || o_alu_op !== 2'd1 || o_key_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d got=v%b a%0d b%0d op%0d rdy%b exp=v1 a1 b2 op1 rdy0", i, o_alu_valid, o_alu_a, o_alu_b, o_alu_op, o_key_ready);
      end
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #2;
    checks++;
    if (o_alu_valid !== 1'b0 || o_alu_a !== 16'd0 || o_alu_b !== 16'd0 || o_alu_op !== 2'd0 || o_key_ready !== 1'b1 || o_display !== 16'd0 || o_display_error !== 1'b0) begin
      errors++;
      $display("FAIL stall_reset got=v%b a%0d b%0d op%0d rdy%b d%0d e%b exp=all reset values", o_alu_valid, o_alu_a, o_alu_b, o_alu_op, o_key_ready, o_display, o_display_error);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_backspace();
    press(KEY_AC); press(5'd1); press(5'd2); press(5'd3); press(KEY_BKSP);
`ifdef CALC_INPUT_BACKSPACE_EN
    checks++; if (o_display !== 16'd12) begin errors++; $display("FAIL backspace got=%0d exp=12", o_display); end
`else
    checks++; if (o_display !== 16'd123) begin errors++; $display("FAIL backspace_ignored got=%0d exp=123", o_display); end
`endif
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_digit_limit();
    test_chain();
    test_error();
    test_stray_result();
    test_stall_reset();
    test_backspace();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
